// File: rtl/priority_resolver_isr.sv
// Priority resolver and In-Service Register for an 8259-style interrupt controller.
// Resolves fixed/rotating priority, runs the two-pulse INTA sequence and handles EOI/AEOI.
module priority_resolver_isr #(
   parameter int NUM_IR = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] risedBits,
   input  logic [4:0] vectorBase,
   input  logic       autoEOI,
   input  logic       rotateMode,
   input  logic       intaPulse,
   input  logic       eoiCmd,
   input  logic       eoiSpecific,
   input  logic [2:0] eoiLevel,
   output logic       intReq,
   output logic [2:0] resetIRR,
   output logic       resetIRRValid,
   output logic [7:0] vectorOut,
   output logic       vectorValid,
   output logic [7:0] isr,
   output logic [2:0] lowestPri
);

   typedef enum logic {IDLE, ACK1} stateT;

   stateT      state, stateNext;
   logic [2:0] levelQ, levelNext;
   logic       spuriousQ, spuriousNext;
   logic [7:0] isrNext;
   logic [2:0] lowestPriNext;
   logic       intReqNext;
   logic [2:0] resetIRRNext;
   logic       resetIRRValidNext;
   logic [7:0] vectorOutNext;
   logic       vectorValidNext;

   logic       candFound, blocked, grant;
   logic [2:0] candLevel;
   logic       eoiFound;
   logic [2:0] eoiNsLevel;

   // Walk levels from highest to lowest priority; an ISR bit seen at or before
   // the candidate blocks it (fully nested mode).
   // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
   always_comb begin : prioScan
      logic [2:0] lvl;
      lvl        = '0;
      candFound  = 1'b0;
      candLevel  = 3'd7;
      blocked    = 1'b0;
      eoiFound   = 1'b0;
      eoiNsLevel = '0;
      for (int k = 0; k < NUM_IR; k++) begin
         lvl = lowestPri + 3'd1 + 3'(k);
         if (!candFound) begin
            if (isr[lvl]) blocked = 1'b1;
            if (risedBits[lvl]) begin
               candFound = 1'b1;
               candLevel = lvl;
            end
         end
         if (!eoiFound && isr[lvl]) begin
            eoiFound   = 1'b1;
            eoiNsLevel = lvl;
         end
      end
   end

   assign grant = candFound && !blocked;

   always_comb begin : nextLogic
      logic       setEn, aeoiEn, eoiEn;
      logic [2:0] eoiClr;
      stateNext         = state;
      levelNext         = levelQ;
      spuriousNext      = spuriousQ;
      resetIRRNext      = resetIRR;
      resetIRRValidNext = 1'b0;
      vectorOutNext     = vectorOut;
      vectorValidNext   = 1'b0;
      intReqNext        = (state == IDLE) && grant;
      setEn             = 1'b0;
      aeoiEn            = 1'b0;

      case (state)
         IDLE: if (intaPulse) begin
            stateNext = ACK1;
            if (grant) begin
               levelNext         = candLevel;
               spuriousNext      = 1'b0;
               setEn             = 1'b1;
               resetIRRNext      = candLevel;
               resetIRRValidNext = 1'b1;
            end else begin
               levelNext    = 3'd7;
               spuriousNext = 1'b1;
            end
         end
         ACK1: if (intaPulse) begin
            stateNext       = IDLE;
            vectorOutNext   = {vectorBase, levelQ};
            vectorValidNext = 1'b1;
            aeoiEn          = autoEOI && !spuriousQ;
         end
         default: stateNext = IDLE;
      endcase

      eoiClr = eoiSpecific ? eoiLevel : eoiNsLevel;
      eoiEn  = eoiCmd && (eoiSpecific ? isr[eoiLevel] : eoiFound);

      // Ordering encodes the collision rules: a set beats an EOI clear, and an
      // EOI rotation beats an AEOI rotation.
      isrNext = isr;
      if (eoiEn)  isrNext[eoiClr]    = 1'b0;
      if (aeoiEn) isrNext[levelQ]    = 1'b0;
      if (setEn)  isrNext[candLevel] = 1'b1;

      lowestPriNext = lowestPri;
      if (aeoiEn && rotateMode) lowestPriNext = levelQ;
      if (eoiEn && rotateMode)  lowestPriNext = eoiClr;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         levelQ        <= '0;
         spuriousQ     <= 1'b0;
         isr           <= '0;
         lowestPri     <= 3'd7;
         intReq        <= 1'b0;
         resetIRR      <= '0;
         resetIRRValid <= 1'b0;
         vectorOut     <= '0;
         vectorValid   <= 1'b0;
      end else begin
         state         <= stateNext;
         levelQ        <= levelNext;
         spuriousQ     <= spuriousNext;
         isr           <= isrNext;
         lowestPri     <= lowestPriNext;
         intReq        <= intReqNext;
         resetIRR      <= resetIRRNext;
         resetIRRValid <= resetIRRValidNext;
         vectorOut     <= vectorOutNext;
         vectorValid   <= vectorValidNext;
      end
   end

endmodule

// File: tb/tb_priority_resolver_isr.sv
// Directed bench for priority_resolver_isr: a cycle-by-cycle vector table
// followed by hand-written reset-abort and specific-EOI sequences.
module tb_priority_resolver_isr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] risedBits;
   logic [4:0] vectorBase;
   logic       autoEOI, rotateMode, intaPulse, eoiCmd, eoiSpecific;
   logic [2:0] eoiLevel;
   logic       intReq, resetIRRValid, vectorValid;
   logic [2:0] resetIRR, lowestPri;
   logic [7:0] vectorOut, isr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   priority_resolver_isr dut (
      .clk(clk), .rst_n(rst_n), .risedBits(risedBits), .vectorBase(vectorBase),
      .autoEOI(autoEOI), .rotateMode(rotateMode), .intaPulse(intaPulse),
      .eoiCmd(eoiCmd), .eoiSpecific(eoiSpecific), .eoiLevel(eoiLevel),
      .intReq(intReq), .resetIRR(resetIRR), .resetIRRValid(resetIRRValid),
      .vectorOut(vectorOut), .vectorValid(vectorValid), .isr(isr), .lowestPri(lowestPri)
   );

   typedef struct {
      logic [7:0] rb;
      logic [4:0] vb;
      logic       rot, aeoi, inta, eoi, spec;
      logic [2:0] lvl;
      logic       expInt, expRv;
      logic [2:0] expRirr;
      logic       expVv;
      logic [7:0] expVo, expIsr;
      logic [2:0] expLp;
   } vecT;

   vecT vecs[24];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic waitIntReq(input string name);
      for (int i = 0; i < 10 && intReq !== 1'b1; i++) cycle();
      check(name, {7'd0, intReq}, 8'h01);
   endtask

   task automatic pulseInta();
      intaPulse = 1'b1;
      cycle();
      intaPulse = 1'b0;
   endtask

   initial begin
      //            rb     vb   rot aeoi inta eoi spec lvl | int rv rirr vv  vo     isr    lp
      vecs[0]  = '{8'h00, 5'h08, 0, 0, 0, 0, 0, 3'd0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 3'd7};
      vecs[1]  = '{8'h28, 5'h08, 0, 0, 0, 0, 0, 3'd0, 1, 0, 3'd0, 0, 8'h00, 8'h00, 3'd7};
      vecs[2]  = '{8'h28, 5'h08, 0, 0, 1, 0, 0, 3'd0, 1, 1, 3'd3, 0, 8'h00, 8'h08, 3'd7};
      vecs[3]  = '{8'h28, 5'h08, 0, 0, 0, 0, 0, 3'd0, 0, 0, 3'd3, 0, 8'h00, 8'h08, 3'd7};
      vecs[4]  = '{8'h28, 5'h08, 0, 0, 1, 0, 0, 3'd0, 0, 0, 3'd3, 1, 8'h43, 8'h08, 3'd7};
      vecs[5]  = '{8'h20, 5'h08, 0, 0, 0, 0, 0, 3'd0, 0, 0, 3'd3, 0, 8'h43, 8'h08, 3'd7};
      vecs[6]  = '{8'h22, 5'h08, 0, 0, 0, 0, 0, 3'd0, 1, 0, 3'd3, 0, 8'h43, 8'h08, 3'd7};
      vecs[7]  = '{8'h22, 5'h08, 0, 0, 1, 0, 0, 3'd0, 1, 1, 3'd1, 0, 8'h43, 8'h0A, 3'd7};
      vecs[8]  = '{8'h20, 5'h08, 0, 0, 0, 0, 0, 3'd0, 0, 0, 3'd1, 0, 8'h43, 8'h0A, 3'd7};
      vecs[9]  = '{8'h20, 5'h08, 0, 0, 1, 0, 0, 3'd0, 0, 0, 3'd1, 1, 8'h41, 8'h0A, 3'd7};
      vecs[10] = '{8'h20, 5'h08, 0, 0, 0, 1, 0, 3'd0, 0, 0, 3'd1, 0, 8'h41, 8'h08, 3'd7};
      vecs[11] = '{8'h20, 5'h08, 0, 0, 0, 1, 0, 3'd0, 0, 0, 3'd1, 0, 8'h41, 8'h00, 3'd7};
      vecs[12] = '{8'h00, 5'h08, 0, 0, 0, 0, 0, 3'd0, 0, 0, 3'd1, 0, 8'h41, 8'h00, 3'd7};
      vecs[13] = '{8'h01, 5'h08, 1, 1, 0, 0, 0, 3'd0, 1, 0, 3'd1, 0, 8'h41, 8'h00, 3'd7};
      vecs[14] = '{8'h01, 5'h08, 1, 1, 1, 0, 0, 3'd0, 1, 1, 3'd0, 0, 8'h41, 8'h01, 3'd7};
      vecs[15] = '{8'h00, 5'h08, 1, 1, 0, 0, 0, 3'd0, 0, 0, 3'd0, 0, 8'h41, 8'h01, 3'd7};
      vecs[16] = '{8'h00, 5'h08, 1, 1, 1, 0, 0, 3'd0, 0, 0, 3'd0, 1, 8'h40, 8'h00, 3'd0};
      vecs[17] = '{8'h81, 5'h08, 1, 1, 0, 0, 0, 3'd0, 1, 0, 3'd0, 0, 8'h40, 8'h00, 3'd0};
      vecs[18] = '{8'h81, 5'h08, 1, 1, 1, 0, 0, 3'd0, 1, 1, 3'd7, 0, 8'h40, 8'h80, 3'd0};
      vecs[19] = '{8'h01, 5'h08, 1, 1, 0, 0, 0, 3'd0, 0, 0, 3'd7, 0, 8'h40, 8'h80, 3'd0};
      vecs[20] = '{8'h01, 5'h08, 1, 1, 1, 0, 0, 3'd0, 0, 0, 3'd7, 1, 8'h47, 8'h00, 3'd7};
      vecs[21] = '{8'h00, 5'h1F, 0, 0, 0, 0, 0, 3'd0, 0, 0, 3'd7, 0, 8'h47, 8'h00, 3'd7};
      vecs[22] = '{8'h00, 5'h1F, 0, 0, 1, 0, 0, 3'd0, 0, 0, 3'd7, 0, 8'h47, 8'h00, 3'd7};
      vecs[23] = '{8'h00, 5'h1F, 0, 0, 1, 0, 0, 3'd0, 0, 0, 3'd7, 1, 8'hFF, 8'h00, 3'd7};

      rst_n = 1'b0;
      risedBits = '0; vectorBase = 5'h08; autoEOI = 0; rotateMode = 0;
      intaPulse = 0; eoiCmd = 0; eoiSpecific = 0; eoiLevel = '0;
      cycle();
      cycle();
      check("reset isr", isr, 8'h00);
      check("reset lowestPri", {5'd0, lowestPri}, 8'h07);
      check("reset intReq", {7'd0, intReq}, 8'h00);
      check("reset vectorOut", vectorOut, 8'h00);
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         risedBits   = vecs[i].rb;
         vectorBase  = vecs[i].vb;
         rotateMode  = vecs[i].rot;
         autoEOI     = vecs[i].aeoi;
         intaPulse   = vecs[i].inta;
         eoiCmd      = vecs[i].eoi;
         eoiSpecific = vecs[i].spec;
         eoiLevel    = vecs[i].lvl;
         cycle();
         check($sformatf("row%0d intReq", i), {7'd0, intReq}, {7'd0, vecs[i].expInt});
         check($sformatf("row%0d resetIRRValid", i), {7'd0, resetIRRValid}, {7'd0, vecs[i].expRv});
         check($sformatf("row%0d resetIRR", i), {5'd0, resetIRR}, {5'd0, vecs[i].expRirr});
         check($sformatf("row%0d vectorValid", i), {7'd0, vectorValid}, {7'd0, vecs[i].expVv});
         check($sformatf("row%0d vectorOut", i), vectorOut, vecs[i].expVo);
         check($sformatf("row%0d isr", i), isr, vecs[i].expIsr);
         check($sformatf("row%0d lowestPri", i), {5'd0, lowestPri}, {5'd0, vecs[i].expLp});
      end
      intaPulse = 0; eoiCmd = 0;

      // Async reset in the middle of an acknowledge sequence.
      risedBits = 8'h10; vectorBase = 5'h08; rotateMode = 0; autoEOI = 0;
      waitIntReq("abort intReq");
      pulseInta();
      check("abort resetIRRValid", {7'd0, resetIRRValid}, 8'h01);
      check("abort resetIRR", {5'd0, resetIRR}, 8'h04);
      check("abort isr set", isr, 8'h10);
      risedBits = 8'h00;
      #2 rst_n = 1'b0;
      #1;
      check("abort isr cleared", isr, 8'h00);
      check("abort intReq", {7'd0, intReq}, 8'h00);
      check("abort lowestPri", {5'd0, lowestPri}, 8'h07);
      cycle();
      rst_n = 1'b1;
      begin
         logic sawVv;
         sawVv = 1'b0;
         for (int i = 0; i < 4; i++) begin
            cycle();
            if (vectorValid) sawVv = 1'b1;
         end
         check("abort no vectorValid", {7'd0, sawVv}, 8'h00);
      end

      // Specific EOI with rotation, then a specific EOI that is a no-op.
      risedBits = 8'h10;
      waitIntReq("seoi intReq");
      pulseInta();
      risedBits = 8'h00;
      cycle();
      pulseInta();
      check("seoi vectorValid", {7'd0, vectorValid}, 8'h01);
      check("seoi vectorOut", vectorOut, 8'h44);
      check("seoi isr before", isr, 8'h10);
      rotateMode = 1; eoiCmd = 1; eoiSpecific = 1; eoiLevel = 3'd4;
      cycle();
      eoiCmd = 0;
      check("seoi isr after", isr, 8'h00);
      check("seoi rotate", {5'd0, lowestPri}, 8'h04);
      eoiCmd = 1; eoiLevel = 3'd2;
      cycle();
      eoiCmd = 0;
      check("seoi noop keeps lowestPri", {5'd0, lowestPri}, 8'h04);
      check("seoi noop isr", isr, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
